// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - shared types and constants for the framebuffer write port
package fb_pkg;

    localparam int ADDR_W = 16;

    localparam logic [3:0] OFF_COLOR  = 4'h0;
    localparam logic [3:0] OFF_START  = 4'h4;
    localparam logic [3:0] OFF_LEN_GO = 4'h8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        FILL  = 2'd2
    } fbw_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] idx;
        logic [23:0]       rgb;
    } pix_entry_t;

endpackage

// File: rtl/fb_write_port_if.sv
// rtl/fb_write_port_if.sv - memory-stage store bus into the framebuffer write port
interface fb_write_port_if;

    logic        mem_write_m;
    logic [31:0] addr_m;
    logic [31:0] wdata_m;
    logic        stall_req;

    modport master (
        output mem_write_m,
        output addr_m,
        output wdata_m,
        input  stall_req
    );

    modport slave (
        input  mem_write_m,
        input  addr_m,
        input  wdata_m,
        output stall_req
    );

endinterface

// File: rtl/fb_sync_fifo.sv
// rtl/fb_sync_fifo.sv - single-clock store buffer with occupancy count
module fb_sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 40
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    logic do_push;
    logic do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    assign count   = wr_ptr - rd_ptr;
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr[AW-1:0]];

    // Pointer update; contents are lost on reset by design
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage array write, no reset needed on the data itself
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/fb_write_port.sv
// rtl/fb_write_port.sv - buffered framebuffer writer with linear fill engine
module fb_write_port
    import fb_pkg::*;
#(
    parameter logic [31:0] FB_BASE    = 32'h0001_0000,
    parameter logic [31:0] CTRL_BASE  = 32'h0002_0000,
    parameter int          FB_WORDS   = 40000,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    fb_write_port_if.slave    sif,
    input  logic              port_free,
    output logic              fb_we,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [23:0]       fb_wdata,
    output logic              busy,
    output logic              err
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [31:0]   FB_END   = FB_BASE + (32'd4 << ADDR_W);
    localparam logic [ADDR_W:0] WORDS_X = (ADDR_W+1)'(FB_WORDS);

    fbw_state_t        state;
    logic              go_pend;
    logic [ADDR_W:0]   cnt;
    logic [CW-1:0]     drain_left;

    logic [23:0]       fill_color;
    logic [ADDR_W-1:0] fill_start;
    logic [ADDR_W-1:0] fill_len;

    logic              ctrl_hit;
    logic              pix_win;
    logic              pix_ok;
    logic [ADDR_W-1:0] idx;
    logic [3:0]        ctrl_word;
    logic              ctrl_block;
    logic              ctrl_we;
    logic              bypass;
    logic              push;
    logic              pop;
    logic              fsm_idle;
    logic [ADDR_W:0]   fill_pos;
    logic              fill_done;
    logic              fill_wr;

    pix_entry_t        fifo_din;
    pix_entry_t        fifo_dout;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CW-1:0]     fifo_count;

    // The control block sits inside the pixel window, so it shadows those pixels
    assign ctrl_hit  = sif.mem_write_m && (sif.addr_m >= CTRL_BASE) && (sif.addr_m < CTRL_BASE + 32'd16);
    assign pix_win   = sif.mem_write_m && !ctrl_hit && (sif.addr_m >= FB_BASE) && (sif.addr_m < FB_END);
    assign idx       = sif.addr_m[ADDR_W+1:2] - FB_BASE[ADDR_W+1:2];
    assign pix_ok    = pix_win && ({1'b0, idx} < WORDS_X);
    assign ctrl_word = {sif.addr_m[3:2], 2'b00};

    assign fsm_idle   = (state == IDLE);
    assign ctrl_block = ctrl_hit && (!fsm_idle || go_pend);
    assign ctrl_we    = ctrl_hit && !ctrl_block;

    // An empty, quiet port forwards the store straight to the output register
    assign bypass = pix_ok && fifo_empty && fsm_idle && !go_pend && port_free;
    assign push   = pix_ok && !fifo_full && !bypass;
    assign pop    = port_free && ((fsm_idle && !go_pend && !fifo_empty) || (state == DRAIN));

    assign sif.stall_req = (pix_ok && fifo_full) || ctrl_block;

    assign fill_pos  = {1'b0, fill_start} + cnt;
    assign fill_done = (cnt == {1'b0, fill_len}) || (fill_pos >= WORDS_X);
    assign fill_wr   = (state == FILL) && !fill_done && port_free;

    assign busy = !fifo_empty || !fsm_idle || go_pend;

    assign fifo_din.idx = idx;
    assign fifo_din.rgb = sif.wdata_m[23:0];

    fb_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(pix_entry_t))
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   (fifo_din),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Fill control registers, only writable while no fill is pending or running
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fill_color <= '0;
            fill_start <= '0;
            fill_len   <= '0;
        end else if (ctrl_we) begin
            case (ctrl_word)
                OFF_COLOR:  fill_color <= sif.wdata_m[23:0];
                OFF_START:  fill_start <= sif.wdata_m[ADDR_W-1:0];
                OFF_LEN_GO: fill_len   <= sif.wdata_m[ADDR_W-1:0];
                default:    ;
            endcase
        end
    end

    // Sticky flag for stores that land in the window beyond the last pixel
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) err <= 1'b0;
        else if (pix_win && !pix_ok) err <= 1'b1;
    end

    // Sequencer: drains stores older than the fill, then runs the fill, with registered RAM outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            go_pend    <= 1'b0;
            cnt        <= '0;
            drain_left <= '0;
            fb_we      <= 1'b0;
            fb_addr    <= '0;
            fb_wdata   <= '0;
        end else begin
            fb_we <= 1'b0;
            if (bypass) begin
                fb_we    <= 1'b1;
                fb_addr  <= idx;
                fb_wdata <= sif.wdata_m[23:0];
            end else if (pop) begin
                fb_we    <= 1'b1;
                fb_addr  <= fifo_dout.idx;
                fb_wdata <= fifo_dout.rgb;
            end else if (fill_wr) begin
                fb_we    <= 1'b1;
                fb_addr  <= fill_pos[ADDR_W-1:0];
                fb_wdata <= fill_color;
            end

            if (ctrl_we && (ctrl_word == OFF_LEN_GO)) go_pend <= 1'b1;

            case (state)
                IDLE: begin
                    if (go_pend) begin
                        cnt <= '0;
                        if (fifo_empty) begin
                            state <= FILL;
                        end else begin
                            state      <= DRAIN;
                            drain_left <= fifo_count;
                        end
                    end
                end
                DRAIN: begin
                    if (port_free) begin
                        drain_left <= drain_left - 1'b1;
                        if (drain_left == CW'(1)) state <= FILL;
                    end
                end
                FILL: begin
                    if (fill_done) begin
                        state   <= IDLE;
                        go_pend <= 1'b0;
                    end else if (port_free) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fb_write_port.sv
// tb/tb_fb_write_port.sv - directed self-checking bench for fb_write_port
module tb_fb_write_port;

    localparam logic [31:0] FB_BASE   = 32'h0001_0000;
    localparam logic [31:0] CTRL_BASE = 32'h0002_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        port_free = 1'b0;
    logic        fb_we;
    logic [15:0] fb_addr;
    logic [23:0] fb_wdata;
    logic        busy;
    logic        err;

    int checks = 0;
    int errors = 0;

    logic [39:0] wq[$];

    fb_write_port_if sif ();

    fb_write_port dut (
        .clk       (clk),
        .reset     (reset),
        .sif       (sif),
        .port_free (port_free),
        .fb_we     (fb_we),
        .fb_addr   (fb_addr),
        .fb_wdata  (fb_wdata),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reset && fb_we) wq.push_back({fb_addr, fb_wdata});
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] d);
        int n;
        n = 0;
        sif.mem_write_m = 1'b1;
        sif.addr_m      = a;
        sif.wdata_m     = d;
        #1;
        while (sif.stall_req && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 200) chk("store_timeout", 64'(n), 64'(0));
        @(negedge clk);
        sif.mem_write_m = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 64'(busy), 64'(0));
        repeat (2) @(negedge clk);
    endtask

    task automatic chk_wr(input string tag, input int pos, input logic [15:0] a, input logic [23:0] d);
        if (pos < wq.size()) chk(tag, 64'(wq[pos]), 64'({a, d}));
        else chk(tag, 64'(0), 64'({a, d}));
    endtask

    initial begin
        int n;
        int sz;
        logic [15:0] exp_a [6];
        logic [23:0] exp_d [6];

        sif.mem_write_m = 1'b0;
        sif.addr_m      = '0;
        sif.wdata_m     = '0;

        repeat (3) @(negedge clk);
        chk("rst_fb_we", 64'(fb_we), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_err", 64'(err), 64'(0));
        chk("rst_stall", 64'(sif.stall_req), 64'(0));
        reset = 1'b1;
        @(negedge clk);

        // Test 1: single store forwards on the next cycle
        port_free       = 1'b1;
        sif.mem_write_m = 1'b1;
        sif.addr_m      = FB_BASE + 32'd8;
        sif.wdata_m     = 32'h00AA_BBCC;
        @(posedge clk);
        #1;
        chk("t1_fb_we", 64'(fb_we), 64'(1));
        chk("t1_fb_addr", 64'(fb_addr), 64'(2));
        chk("t1_fb_wdata", 64'(fb_wdata), 64'(24'hAABBCC));
        @(negedge clk);
        sif.mem_write_m = 1'b0;
        wait_idle("t1_idle");
        wq.delete();

        // Test 2: fill the buffer while the port is held
        port_free = 1'b0;
        for (int i = 0; i < 8; i++) begin
            sif.mem_write_m = 1'b1;
            sif.addr_m      = FB_BASE + 32'(4 * (10 + i));
            sif.wdata_m     = 32'h0000_A000 + 32'(i);
            #1;
            chk("t2_nostall", 64'(sif.stall_req), 64'(0));
            @(negedge clk);
        end
        sif.addr_m  = FB_BASE + 32'(4 * 18);
        sif.wdata_m = 32'h0000_A008;
        #1;
        chk("t2_stall9", 64'(sif.stall_req), 64'(1));
        chk("t2_no_wr_held", 64'(wq.size()), 64'(0));
        port_free = 1'b1;
        n = 0;
        while (sif.stall_req && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("t2_release", 64'(sif.stall_req), 64'(0));
        @(negedge clk);
        sif.mem_write_m = 1'b0;
        wait_idle("t2_idle");
        chk("t2_count", 64'(wq.size()), 64'(9));
        for (int i = 0; i < 9; i++)
            chk_wr("t2_order", i, 16'(10 + i), 24'hA000 + 24'(i));
        wq.delete();

        // Test 3: store just past the last pixel
        do_store(FB_BASE + 32'd160000, 32'h0011_2233);
        repeat (2) @(negedge clk);
        chk("t3_no_wr", 64'(wq.size()), 64'(0));
        chk("t3_err", 64'(err), 64'(1));
        do_store(FB_BASE + 32'd28, 32'h0007_0707);
        repeat (2) @(negedge clk);
        chk("t3_err_sticky", 64'(err), 64'(1));
        chk("t3_count", 64'(wq.size()), 64'(1));
        chk_wr("t3_valid_wr", 0, 16'd7, 24'h070707);
        wq.delete();

        // Test 4: fill clipped at the end of the framebuffer
        do_store(CTRL_BASE + 32'd0, 32'h0012_3456);
        do_store(CTRL_BASE + 32'd4, 32'd39998);
        do_store(CTRL_BASE + 32'd8, 32'd5);
        wait_idle("t4_idle");
        chk("t4_count", 64'(wq.size()), 64'(2));
        chk_wr("t4_w0", 0, 16'd39998, 24'h123456);
        chk_wr("t4_w1", 1, 16'd39999, 24'h123456);
        wq.delete();

        // Test 5: ordering of buffered stores around a fill
        port_free = 1'b0;
        do_store(FB_BASE + 32'd20, 32'h0005_0505);
        do_store(FB_BASE + 32'd24, 32'h0006_0606);
        do_store(CTRL_BASE + 32'd0, 32'h0000_FF00);
        do_store(CTRL_BASE + 32'd4, 32'd0);
        do_store(CTRL_BASE + 32'd8, 32'd3);
        do_store(FB_BASE + 32'd4, 32'h0001_0101);
        repeat (3) @(negedge clk);
        chk("t5_held", 64'(wq.size()), 64'(0));
        chk("t5_busy", 64'(busy), 64'(1));
        port_free = 1'b1;
        wait_idle("t5_idle");
        exp_a = '{16'd5, 16'd6, 16'd0, 16'd1, 16'd2, 16'd1};
        exp_d = '{24'h050505, 24'h060606, 24'h00FF00, 24'h00FF00, 24'h00FF00, 24'h010101};
        chk("t5_count", 64'(wq.size()), 64'(6));
        for (int i = 0; i < 6; i++)
            chk_wr("t5_order", i, exp_a[i], exp_d[i]);
        wq.delete();

        // Test 6: reset asserted in the middle of a fill
        do_store(CTRL_BASE + 32'd0, 32'h0077_7777);
        do_store(CTRL_BASE + 32'd4, 32'd100);
        do_store(CTRL_BASE + 32'd8, 32'd10);
        n = 0;
        while (!(fb_we && fb_addr == 16'd101) && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("t6_reach_cnt2", 64'(fb_we && fb_addr == 16'd101), 64'(1));
        reset = 1'b0;
        #1;
        chk("t6_fb_we_async", 64'(fb_we), 64'(0));
        chk("t6_busy_async", 64'(busy), 64'(0));
        chk_wr("t6_first", 0, 16'd100, 24'h777777);
        sz = wq.size();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (20) @(negedge clk);
        chk("t6_no_more_wr", 64'(wq.size()), 64'(sz));
        chk("t6_busy_after", 64'(busy), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
